match_sequencer: RTL and testbench

Round/match controller for the tug-of-war game. Sits between `input_processing` (one-cycle press pulses per player) and `light_control` (playfield), sequencing a best-of match: idle, countdown, play, score, done. It gates and arbitrates player moves, resets the playfield between rounds, and keeps a per-player round score until one player reaches the match target.

---
 rtl/game_pkg.sv | 17 +
 rtl/round_timer.sv | 39 +++
 rtl/match_sequencer.sv | 131 +++++++++++++
 tb/tb_match_sequencer.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared types and encodings for the tug-of-war match sequencer
package game_pkg;

  typedef enum logic [2:0] {
    IDLE,
    COUNTDOWN,
    PLAY,
    SCORE,
    DONE
  } match_state_t;

  // winner output encodings
  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_P1   = 2'b10;
  localparam logic [1:0] WIN_P2   = 2'b01;

endpackage

// File: rtl/round_timer.sv
// rtl/round_timer.sv - loadable down-counter timing the pre-round countdown
//   clk   : system clock
//   reset : synchronous, active-high
//   load  : reload with COUNT_CYCLES-1 on the next edge
//   done  : count has reached zero
module round_timer #(
  parameter int COUNT_CYCLES = 50_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  output logic done
);

  localparam int TW = $clog2(COUNT_CYCLES);

  logic [TW-1:0] cnt_q, cnt_d;

  // Counter parks at zero once expired so done stays high until the next load.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = TW'(COUNT_CYCLES - 1);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - TW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done = (cnt_q == '0);

endmodule

// File: rtl/match_sequencer.sv
// rtl/match_sequencer.sv - best-of match controller: idle, countdown, play, score, done
//   clk, reset          : clock, synchronous active-high reset
//   p1_press, p2_press  : one-cycle press pulses
//   p1_wins, p2_wins    : round-end levels from the playfield
//   p1_move, p2_move    : gated, registered move pulses to the playfield
//   field_reset         : holds the playfield at centre
//   score1, score2      : rounds won per player
//   match_over, winner  : match result
module match_sequencer
  import game_pkg::*;
#(
  parameter int WIN_SCORE    = 3,
  parameter int COUNT_CYCLES = 50_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       p1_press,
  input  logic       p2_press,
  input  logic       p1_wins,
  input  logic       p2_wins,
  output logic       p1_move,
  output logic       p2_move,
  output logic       field_reset,
  output logic [2:0] score1,
  output logic [2:0] score2,
  output logic       match_over,
  output logic [1:0] winner
);

  localparam logic [2:0] WIN_S = 3'(WIN_SCORE);

  match_state_t state_q;
  logic         round_p1_q;   // player 1 took the round being scored
  logic         p1_move_q, p2_move_q, field_reset_q, match_over_q;
  logic [2:0]   score1_q, score2_q;
  logic [1:0]   winner_q;

  logic       press_any;
  logic       timer_load;
  logic       timer_done;
  logic [2:0] win_score_d;
  logic       match_won;

  assign press_any = p1_press | p2_press;

  // Score the round winner would reach this SCORE cycle.
  assign win_score_d = round_p1_q ? (score1_q + 3'd1) : (score2_q + 3'd1);
  assign match_won   = (win_score_d == WIN_S);

  // The timer must load on the same edge the state enters COUNTDOWN so the
  // countdown spans exactly COUNT_CYCLES cycles.
  assign timer_load = ((state_q == IDLE) && press_any) ||
                      ((state_q == SCORE) && !match_won);

  round_timer #(
    .COUNT_CYCLES(COUNT_CYCLES)
  ) u_round_timer (
    .clk  (clk),
    .reset(reset),
    .load (timer_load),
    .done (timer_done)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      round_p1_q    <= 1'b0;
      p1_move_q     <= 1'b0;
      p2_move_q     <= 1'b0;
      field_reset_q <= 1'b1;
      score1_q      <= 3'd0;
      score2_q      <= 3'd0;
      match_over_q  <= 1'b0;
      winner_q      <= WIN_NONE;
    end else begin
      p1_move_q <= 1'b0;
      p2_move_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (press_any) state_q <= COUNTDOWN;
        end
        COUNTDOWN: begin
          if (timer_done) begin
            state_q       <= PLAY;
            field_reset_q <= 1'b0;
          end
        end
        PLAY: begin
          // A press coinciding with the round end is dropped.
          if (p1_wins || p2_wins) begin
            state_q    <= SCORE;
            round_p1_q <= p1_wins;
          end else begin
            p1_move_q <= p1_press & ~p2_press;
            p2_move_q <= p2_press & ~p1_press;
          end
        end
        SCORE: begin
          if (round_p1_q) begin
            if (score1_q < WIN_S) score1_q <= win_score_d;
          end else begin
            if (score2_q < WIN_S) score2_q <= win_score_d;
          end
          if (match_won) begin
            state_q      <= DONE;
            match_over_q <= 1'b1;
            winner_q     <= round_p1_q ? WIN_P1 : WIN_P2;
          end else begin
            state_q       <= COUNTDOWN;
            field_reset_q <= 1'b1;
          end
        end
        DONE: begin
          state_q <= DONE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign p1_move     = p1_move_q;
  assign p2_move     = p2_move_q;
  assign field_reset = field_reset_q;
  assign score1      = score1_q;
  assign score2      = score2_q;
  assign match_over  = match_over_q;
  assign winner      = winner_q;

endmodule

// File: tb/tb_match_sequencer.sv
// tb/tb_match_sequencer.sv - scoreboard bench for match_sequencer
module tb_match_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       p1_press = 1'b0;
  logic       p2_press = 1'b0;
  logic       p1_wins = 1'b0;
  logic       p2_wins = 1'b0;
  logic       p1_move, p2_move, field_reset, match_over;
  logic [2:0] score1, score2;
  logic [1:0] winner;

  match_sequencer #(
    .WIN_SCORE   (3),
    .COUNT_CYCLES(4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .p1_press   (p1_press),
    .p2_press   (p2_press),
    .p1_wins    (p1_wins),
    .p2_wins    (p2_wins),
    .p1_move    (p1_move),
    .p2_move    (p2_move),
    .field_reset(field_reset),
    .score1     (score1),
    .score2     (score2),
    .match_over (match_over),
    .winner     (winner)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         at;
    logic [9:0] val;
  } ev_t;

  ev_t stat_q[$];
  ev_t move_q[$];
  int  checks = 0;
  int  errors = 0;
  bit  mon_en = 1'b0;
  bit  all_done = 1'b0;

  // Status snapshot {field_reset, score1, score2, match_over, winner};
  // at = -1 means the cycle is not checked.
  task automatic exp_status(input int at, input logic fr, input logic [2:0] s1,
                            input logic [2:0] s2, input logic mo, input logic [1:0] w);
    ev_t e;
    e.at  = at;
    e.val = {fr, s1, s2, mo, w};
    stat_q.push_back(e);
  endtask

  task automatic exp_move(input int at, input logic [1:0] mv);
    ev_t e;
    e.at  = at;
    e.val = {8'd0, mv};
    move_q.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input logic a, input logic b);
    p1_press = a;
    p2_press = b;
    step(1);
    p1_press = 1'b0;
    p2_press = 1'b0;
  endtask

  // Round starting in PLAY; wins held into countdown (or DONE) and a press
  // is issued with the win so it must be dropped.
  task automatic play_round(input logic w1, input logic w2, input logic [2:0] s1,
                            input logic [2:0] s2, input bit last);
    int n;
    n = cyc;
    if (last) begin
      exp_status(n + 2, 1'b0, s1, s2, 1'b1, w1 ? 2'b10 : 2'b01);
    end else begin
      exp_status(n + 2, 1'b1, s1, s2, 1'b0, 2'b00);
      exp_status(n + 6, 1'b0, s1, s2, 1'b0, 2'b00);
    end
    p1_wins  = w1;
    p2_wins  = w2;
    p1_press = 1'b1;
    step(1);
    p1_press = 1'b0;
    step(4);
    p1_wins = 1'b0;
    p2_wins = 1'b0;
    step(1);
  endtask

  // Monitor: compares whenever status changes or a move pulse appears.
  logic [9:0] prev_stat;
  bit         first = 1'b1;
  always @(negedge clk) begin
    logic [9:0] cur;
    logic [1:0] mv;
    ev_t        e;
    if (mon_en) begin
      cur = {field_reset, score1, score2, match_over, winner};
      if (first || cur !== prev_stat) begin
        checks++;
        if (stat_q.size() == 0) begin
          errors++;
          $display("FAIL status_unexpected cyc=%0d got=%b", cyc, cur);
        end else begin
          e = stat_q.pop_front();
          if (cur !== e.val || (e.at >= 0 && e.at != cyc)) begin
            errors++;
            $display("FAIL status cyc=%0d got=%b expected=%b at cyc %0d", cyc, cur, e.val, e.at);
          end
        end
        prev_stat = cur;
        first     = 1'b0;
      end
      mv = {p1_move, p2_move};
      if (mv != 2'b00) begin
        checks++;
        if (move_q.size() == 0) begin
          errors++;
          $display("FAIL move_unexpected cyc=%0d got=%b", cyc, mv);
        end else begin
          e = move_q.pop_front();
          if (mv !== e.val[1:0] || e.at != cyc) begin
            errors++;
            $display("FAIL move cyc=%0d got=%b expected=%b at cyc %0d", cyc, mv, e.val[1:0], e.at);
          end
        end
      end
    end
    if (all_done) begin
      checks++;
      if (stat_q.size() != 0) begin
        errors++;
        $display("FAIL status_pending got=%0d left expected=0", stat_q.size());
      end
      checks++;
      if (move_q.size() != 0) begin
        errors++;
        $display("FAIL move_pending got=%0d left expected=0", move_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired before end of stimulus");
    $fatal(1);
  end

  initial begin
    int k, m, n, r;
    step(3);
    reset = 1'b0;
    exp_status(-1, 1'b1, 3'd0, 3'd0, 1'b0, 2'b00);
    mon_en = 1'b1;
    step(2);

    // IDLE press, countdown with ignored presses (incl. its last cycle)
    k = cyc;
    exp_status(k + 5, 1'b0, 3'd0, 3'd0, 1'b0, 2'b00);
    press(1'b1, 1'b0);
    press(1'b0, 1'b1);
    step(2);
    press(1'b1, 1'b0);

    // PLAY gating and arbitration
    m = cyc;
    exp_move(m + 1, 2'b10);
    press(1'b1, 1'b0);
    press(1'b1, 1'b1);
    exp_move(m + 3, 2'b01);
    press(1'b0, 1'b1);
    step(1);

    // p2 round, tie-break round, then p1 takes the match
    play_round(1'b0, 1'b1, 3'd0, 3'd1, 1'b0);
    play_round(1'b1, 1'b1, 3'd1, 3'd1, 1'b0);
    play_round(1'b1, 1'b0, 3'd2, 3'd1, 1'b0);
    play_round(1'b1, 1'b0, 3'd3, 3'd1, 1'b1);

    // DONE ignores presses and wins
    press(1'b1, 1'b0);
    press(1'b1, 1'b1);
    press(1'b0, 1'b1);
    p2_wins = 1'b1;
    step(2);
    p2_wins = 1'b0;
    step(1);

    // reset beats a simultaneous press in DONE: must stay IDLE
    r = cyc;
    exp_status(r + 1, 1'b1, 3'd0, 3'd0, 1'b0, 2'b00);
    reset    = 1'b1;
    p1_press = 1'b1;
    step(1);
    reset    = 1'b0;
    p1_press = 1'b0;
    step(8);

    // new match, score a round, reset two cycles into countdown
    k = cyc;
    exp_status(k + 5, 1'b0, 3'd0, 3'd0, 1'b0, 2'b00);
    press(1'b1, 1'b0);
    step(4);
    n = cyc;
    exp_status(n + 2, 1'b1, 3'd0, 3'd1, 1'b0, 2'b00);
    p2_wins = 1'b1;
    step(1);
    p2_wins = 1'b0;
    step(2);
    exp_status(n + 4, 1'b1, 3'd0, 3'd0, 1'b0, 2'b00);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    step(8);

    // sequencer still works after the reset
    k = cyc;
    exp_status(k + 5, 1'b0, 3'd0, 3'd0, 1'b0, 2'b00);
    press(1'b0, 1'b1);
    step(4);
    m = cyc;
    exp_move(m + 1, 2'b01);
    press(1'b0, 1'b1);
    step(3);

    all_done = 1'b1;
  end

endmodule
